// File: rtl/alu_pkg.sv
// Shared ALUControl encodings and execute-stage types. The decoder and the
// execute block both import this, so the codes live in exactly one place.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_BGE   = 4'b1000;
    localparam logic [3:0] ALU_XOR   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SH_LEFT,
        SH_RIGHT,
        SH_ARITH
    } shift_mode_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

    function automatic shift_mode_t shift_mode(input logic [3:0] code);
        shift_mode_t m;
        case (code)
            ALU_SLL: m = SH_LEFT;
            ALU_SRA: m = SH_ARITH;
            default: m = SH_RIGHT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: one bit position per cycle. done pulses on the cycle
// whose rising edge performs the final shift; shifted is the value it produces.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  shift_mode_t        mode,
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               done,
    output logic [WIDTH-1:0]   shifted
);

    logic [WIDTH-1:0]   acc_reg;
    logic [SHAMT_W-1:0] count_reg;
    shift_mode_t        mode_reg;
    logic               busy;
    logic               msb_fill;

    assign busy     = (count_reg != '0);
    assign done     = (count_reg == SHAMT_W'(1));
    assign msb_fill = (mode_reg == SH_ARITH) ? acc_reg[WIDTH-1] : 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            logic from_below;
            logic from_above;
            if (gi == 0) begin : g_lsb
                assign from_below = 1'b0;
            end else begin : g_mid_lo
                assign from_below = acc_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_msb
                assign from_above = msb_fill;
            end else begin : g_mid_hi
                assign from_above = acc_reg[gi+1];
            end
            assign shifted[gi] = (mode_reg == SH_LEFT) ? from_below : from_above;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg   <= '0;
            count_reg <= '0;
            mode_reg  <= SH_LEFT;
        end else if (start) begin
            acc_reg   <= data;
            count_reg <= shamt;
            mode_reg  <= mode;
        end else if (busy) begin
            acc_reg   <= shifted;
            count_reg <= count_reg - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/serial_alu_exec.sv
// Execute-stage ALU with valid/ready on both sides. Single-cycle ops finish
// in one cycle; non-zero shifts are handed to the bit-serial shifter.
module serial_alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    state_t             state_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               zero_reg;
    logic               illegal_reg;

    logic [WIDTH-1:0]   op_result;
    logic               op_illegal;
    logic               signed_lt;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;
    logic               start_shift;
    logic               shift_done;
    logic [WIDTH-1:0]   shift_result;

    assign shamt       = src_b[SHAMT_W-1:0];
    assign signed_lt   = $signed(src_a) < $signed(src_b);
    assign accept      = in_valid && (state_reg == IDLE);
    assign start_shift = accept && is_shift(alu_control) && (shamt != '0);

    // Shift codes land here only when shamt is zero, so they just pass A.
    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        case (alu_control)
            ALU_ADD:   op_result = src_a + src_b;
            ALU_SUB:   op_result = src_a - src_b;
            ALU_AND:   op_result = src_a & src_b;
            ALU_OR:    op_result = src_a | src_b;
            ALU_XOR:   op_result = src_a ^ src_b;
            ALU_SLT,
            ALU_BGE:   op_result = {{(WIDTH-1){1'b0}}, signed_lt};
            ALU_PASSB: op_result = src_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:   op_result = src_a;
            default:   op_illegal = 1'b1;
        endcase
    end

    alu_serial_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .start   (start_shift),
        .mode    (shift_mode(alu_control)),
        .data    (src_a),
        .shamt   (shamt),
        .done    (shift_done),
        .shifted (shift_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        in_ready_reg <= 1'b0;
                        if (start_shift) begin
                            state_reg <= SHIFT;
                        end else begin
                            result_reg    <= op_result;
                            zero_reg      <= (op_result == '0);
                            illegal_reg   <= op_illegal;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end
                end
                // Capture the shifter's last step directly so out_valid
                // appears on the same edge as the final shift.
                SHIFT: begin
                    if (shift_done) begin
                        result_reg    <= shift_result;
                        zero_reg      <= (shift_result == '0);
                        illegal_reg   <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_serial_alu_exec.sv
// Scoreboard bench for serial_alu_exec: stimulus pushes expected responses,
// a negedge monitor pops and compares on every output handshake.
module tb_serial_alu_exec;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [3:0]       alu_control = 4'h0;
    logic [WIDTH-1:0] src_a = '0;
    logic [WIDTH-1:0] src_b = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             ill;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ntx = 0;

    serial_alu_exec #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result 0x%08h, expected no output", result);
            end else begin
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("zero", {31'b0, zero}, {31'b0, e.z});
                check("illegal", {31'b0, illegal}, {31'b0, e.ill});
                $display("txn %0d: result=0x%08h zero=%0b illegal=%0b (expected 0x%08h %0b %0b)",
                         ntx, result, zero, illegal, e.res, e.z, e.ill);
                ntx++;
            end
        end
    end

    // Issue one request; report accept-to-out_valid latency and how many
    // sampled cycles in_ready stayed low after accept.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input logic ei,
                         output int lat, output int low);
        int  n;
        bit  seen;
        exp_q.push_back({er, ez, ei});
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_wait: in_ready got 0 expected 1 within 100 cycles");
        end
        alu_control = c;
        src_a       = a;
        src_b       = b;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        alu_control = ALU_SUB;
        src_a       = 32'hDEADBEEF;
        src_b       = 32'h5A5A5A5A;
        lat  = 0;
        low  = 0;
        seen = 1'b0;
        n    = 0;
        while (n < 200) begin
            n++;
            if (!in_ready) low++;
            if (out_valid && !seen) begin
                seen = 1'b1;
                lat  = n;
            end
            if (seen && in_ready) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input string name, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ez,
                       input logic ei, input int elat);
        int lat, low;
        issue(c, a, b, er, ez, ei, lat, low);
        check({name, "_latency"}, lat, elat);
    endtask

    initial begin
        int lat, low, n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run("add",      ALU_ADD,   32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1);
        run("sub_eq",   ALU_SUB,   32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 1);
        run("bge_lt",   ALU_BGE,   32'hFFFFFFFD,   32'd2,          32'd1,          1'b0, 1'b0, 1);
        run("slt_ge",   ALU_SLT,   32'd5,          32'hFFFFFFFF,   32'd0,          1'b1, 1'b0, 1);
        run("and",      ALU_AND,   32'h0000F0F0,   32'h0000FF00,   32'h0000F000,   1'b0, 1'b0, 1);
        run("or",       ALU_OR,    32'h0000F0F0,   32'h0000FF00,   32'h0000FFF0,   1'b0, 1'b0, 1);
        run("xor",      ALU_XOR,   32'hFF00FF00,   32'h0FF00FF0,   32'hF0F0F0F0,   1'b0, 1'b0, 1);
        run("passb",    ALU_PASSB, 32'd1,          32'h12345000,   32'h12345000,   1'b0, 1'b0, 1);
        run("add_wrap", ALU_ADD,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, 1'b0, 1);

        issue(ALU_SLL, 32'd1, 32'd4, 32'd16, 1'b0, 1'b0, lat, low);
        check("sll4_latency", lat, 32'd5);
        check("sll4_in_ready_low", low, 32'd5);

        run("sra4",     ALU_SRA,   32'h80000000,   32'd4,          32'hF8000000,   1'b0, 1'b0, 5);
        run("srl4",     ALU_SRL,   32'h80000000,   32'd4,          32'h08000000,   1'b0, 1'b0, 5);
        run("sll_sh0",  ALU_SLL,   32'h0000ABCD,   32'h00000020,   32'h0000ABCD,   1'b0, 1'b0, 1);
        run("sll_hi",   ALU_SLL,   32'd3,          32'hFFFFFFE1,   32'd6,          1'b0, 1'b0, 2);
        run("srl31",    ALU_SRL,   32'hFFFFFFFF,   32'd31,         32'd1,          1'b0, 1'b0, 32);
        run("sra31",    ALU_SRA,   32'h80000000,   32'd31,         32'hFFFFFFFF,   1'b0, 1'b0, 32);
        run("srl_zero", ALU_SRL,   32'h00000001,   32'd3,          32'd0,          1'b1, 1'b0, 4);
        run("ill_1010", 4'b1010,   32'd5,          32'd7,          32'd0,          1'b1, 1'b1, 1);
        run("ill_1100", 4'b1100,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          1'b1, 1'b1, 1);

        // Backpressure: hold DONE for 10 cycles and poke in_valid mid-way.
        out_ready = 1'b0;
        exp_q.push_back({32'd7, 1'b0, 1'b0});
        alu_control = ALU_ADD;
        src_a       = 32'd3;
        src_b       = 32'd4;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_result", result, 32'd7);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            if (i == 4) begin
                alu_control = ALU_ADD;
                src_a       = 32'd100;
                src_b       = 32'd1;
                in_valid    = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("bp_no_extra_output", {31'b0, out_valid}, 32'd0);

        // Reset during the third SHIFT cycle aborts the shift with no output.
        alu_control = ALU_SLL;
        src_a       = 32'd1;
        src_b       = 32'd10;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("rst_mid_no_output", {31'b0, out_valid}, 32'd0);

        run("post_rst_add", ALU_ADD, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0, 1);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
